// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states, operation
// encoding and parameter defaults.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_ADDR_W  = 10;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, read data presented on the same
// port so the responder can capture it into its own registered read_data.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are deliberately not reset; they survive a responder reset.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for a pipeline MEM stage: accepts one aligned
// access, stalls LATENCY+1 cycles, then commits the write or captures the load.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        conflict
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    op_t               r_op;
    logic [ADDR_W-1:0] r_index;
    logic [31:0]       r_wdata;
    logic [31:0]       r_read_data;
    logic              r_misaligned;
    logic              r_conflict;

    logic              w_req;
    logic              w_aligned;
    logic              w_accept;
    logic              w_bad;
    logic              w_finish;
    op_t               w_cur_op;
    logic [ADDR_W-1:0] w_cur_index;
    logic [31:0]       w_cur_wdata;
    logic              w_we;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    assign w_req     = mem_read | mem_write;
    assign w_aligned = (address[1:0] == 2'b00);
    assign w_accept  = (r_state == IDLE) && w_req && w_aligned;
    assign w_bad     = (r_state == IDLE) && w_req && !w_aligned;

    // With zero wait states the access completes straight out of IDLE, so the
    // live inputs stand in for the latched copies on that one edge.
    assign w_finish    = ((r_state == WAIT) && (r_count == 4'd1)) ||
                         (w_accept && (LATENCY == 0));
    assign w_cur_op    = (r_state == IDLE) ? (mem_write ? OP_WR : OP_RD) : r_op;
    assign w_cur_index = (r_state == IDLE) ? address[ADDR_W+1:2] : r_index;
    assign w_cur_wdata = (r_state == IDLE) ? write_data : r_wdata;
    assign w_we        = w_finish && (w_cur_op == OP_WR) && !reset;

    assign w_unused_addr = ^{address[31:ADDR_W+2]};

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_cur_index),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_op         <= OP_RD;
            r_index      <= '0;
            r_wdata      <= '0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_conflict   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_bad) begin
                        r_misaligned <= 1'b1;
                        r_read_data  <= '0;
                    end else if (w_accept) begin
                        r_op       <= w_cur_op;
                        r_index    <= w_cur_index;
                        r_wdata    <= write_data;
                        r_conflict <= mem_read && mem_write;
                        if (LATENCY == 0) begin
                            r_state <= DONE;
                            if (w_cur_op == OP_RD) begin
                                r_read_data <= w_rdata;
                            end
                        end else begin
                            r_state <= WAIT;
                            r_count <= LAT_CNT;
                        end
                    end
                end
                WAIT: begin
                    r_count <= r_count - 1'b1;
                    if (r_count == 4'd1) begin
                        r_state <= DONE;
                        if (r_op == OP_RD) begin
                            r_read_data <= w_rdata;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle the request appears, hence combinational.
    assign stall      = !reset && (w_accept || (r_state == WAIT));
    assign read_data  = r_read_data;
    assign misaligned = r_misaligned;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: three responders (LATENCY 2, 0, 3) checked
// against a word-array model of memory contents and expected stall/pulse counts.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b111;
    logic [2:0]  rd_v  = 3'b000;
    logic [2:0]  wr_v  = 3'b000;
    logic [31:0] addr_v [3];
    logic [31:0] wd_v   [3];
    wire  [31:0] rdata_v [3];
    wire  [2:0]  stall_v;
    wire  [2:0]  mis_v;
    wire  [2:0]  conf_v;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model  [3][1024];
    logic [31:0] exp_rd [3];

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(2), .ADDR_W(10)) dut0 (
        .clk(clk), .reset(rst_v[0]), .mem_read(rd_v[0]), .mem_write(wr_v[0]),
        .address(addr_v[0]), .write_data(wd_v[0]), .read_data(rdata_v[0]),
        .stall(stall_v[0]), .misaligned(mis_v[0]), .conflict(conf_v[0]));

    dmem_responder #(.LATENCY(0), .ADDR_W(10)) dut1 (
        .clk(clk), .reset(rst_v[1]), .mem_read(rd_v[1]), .mem_write(wr_v[1]),
        .address(addr_v[1]), .write_data(wd_v[1]), .read_data(rdata_v[1]),
        .stall(stall_v[1]), .misaligned(mis_v[1]), .conflict(conf_v[1]));

    dmem_responder #(.LATENCY(3), .ADDR_W(10)) dut2 (
        .clk(clk), .reset(rst_v[2]), .mem_read(rd_v[2]), .mem_write(wr_v[2]),
        .address(addr_v[2]), .write_data(wd_v[2]), .read_data(rdata_v[2]),
        .stall(stall_v[2]), .misaligned(mis_v[2]), .conflict(conf_v[2]));

    function automatic int lat_of(input int k);
        if (k == 0) return 2;
        if (k == 1) return 0;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, expv);
        end
    endtask

    // One pipeline access: hold the request until stall drops, then release it.
    task automatic access(input int k, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d);
        int  n_stall = 0;
        int  n_mis   = 0;
        int  n_conf  = 0;
        bit  al      = (a[1:0] == 2'b00);
        int  idx     = int'(a[11:2]);
        @(negedge clk);
        rd_v[k] = rd; wr_v[k] = wr; addr_v[k] = a; wd_v[k] = d;
        #1;
        while (stall_v[k] && n_stall < 40) begin
            n_stall++;
            @(negedge clk); #1;
            n_mis  += int'(mis_v[k]);
            n_conf += int'(conf_v[k]);
        end
        if (!al) begin
            @(negedge clk); #1;
            n_mis  += int'(mis_v[k]);
            n_conf += int'(conf_v[k]);
        end
        rd_v[k] = 1'b0; wr_v[k] = 1'b0;
        if (al && wr) model[k][idx] = d;
        else if (al && rd) exp_rd[k] = model[k][idx];
        else if (!al) exp_rd[k] = 32'h0;
        @(negedge clk); #1;
        n_mis  += int'(mis_v[k]);
        n_conf += int'(conf_v[k]);
        check("read_data", rdata_v[k], exp_rd[k]);
        @(negedge clk); #1;
        n_mis  += int'(mis_v[k]);
        n_conf += int'(conf_v[k]);
        check("stall_cycles", n_stall, al ? lat_of(k) + 1 : 0);
        check("misaligned_pulses", n_mis, al ? 0 : 1);
        check("conflict_pulses", n_conf, (al && rd && wr) ? 1 : 0);
        $display("txn inst=%0d rd=%0b wr=%0b addr=%h data=%h stall=%0d rdata=%h",
                 k, rd, wr, a, d, n_stall, rdata_v[k]);
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        for (int k = 0; k < 3; k++) begin
            addr_v[k] = '0; wd_v[k] = '0; exp_rd[k] = '0;
        end
        #3;
        for (int k = 0; k < 3; k++) begin
            check("rst_read_data", rdata_v[k], 32'h0);
            check("rst_flags", {29'h0, stall_v[k], mis_v[k], conf_v[k]}, 32'h0);
        end
        @(negedge clk);
        rst_v = 3'b000;

        // Give every word the random traffic may read a known value.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 32; i++)
                access(k, 1'b0, 1'b1, 32'(i) << 2, $urandom());

        access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
        access(1, 1'b0, 1'b1, 32'h44, 32'h12345678);
        access(1, 1'b1, 1'b0, 32'h44, 32'h0);
        access(0, 1'b1, 1'b0, 32'h42, 32'h0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
        access(0, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5);
        access(0, 1'b1, 1'b0, 32'h80, 32'h0);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hCAFEF00D);
        access(0, 1'b1, 1'b0, 32'h0000, 32'h0);

        // Abort a LATENCY=3 write in its second wait cycle.
        access(2, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        wr_v[2] = 1'b1; addr_v[2] = 32'h10; wd_v[2] = 32'h11111111;
        @(negedge clk);
        @(negedge clk); #1;
        check("stall_before_abort", {31'h0, stall_v[2]}, 32'h1);
        rst_v[2] = 1'b1; wr_v[2] = 1'b0;
        #1;
        check("abort_read_data", rdata_v[2], 32'h0);
        check("abort_flags", {29'h0, stall_v[2], mis_v[2], conf_v[2]}, 32'h0);
        exp_rd[2] = 32'h0;
        @(negedge clk);
        rst_v[2] = 1'b0;
        access(2, 1'b1, 1'b0, 32'h10, 32'h0);

        for (int n = 0; n < 90; n++) begin
            int k = n % 3;
            a = $urandom();
            a[11:2] = 10'($urandom_range(0, 31));
            a[1:0]  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sel = $urandom_range(0, 3);
            access(k, sel != 1, sel == 1 || sel == 2, a, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, wait-state cycles per access (0..15).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width (DEPTH = 2**ADDR_W words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_read  input  1  read request from pipeline MEM stage, held until stall low.
REQ-006 mem_write  input  1  write request from pipeline MEM stage, held until stall low.
REQ-007 address  input  32  byte address; word index = address[ADDR_W+1:2].
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data, registered.
REQ-010 stall  output  1  high while the current request is not complete; pipeline freezes.
REQ-011 misaligned  output  1  one-cycle pulse, address[1:0] != 0 on a request.
REQ-012 conflict  output  1  one-cycle pulse, mem_read and mem_write both high on acceptance.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE with aligned request: SHALL latch op, word index, write_data; go to WAIT with counter = LATENCY, or to DONE if LATENCY = 0.
REQ-015 stall SHALL be combinationally high in IDLE when an aligned request is present, and high throughout WAIT.
REQ-016 WAIT SHALL decrement counter each cycle; at counter = 1, go to DONE.
REQ-017 Total stall cycles per aligned access SHALL equal LATENCY + 1.
REQ-018 On the WAIT->DONE edge (or IDLE->DONE if LATENCY = 0), write SHALL commit to the array; read SHALL load read_data.
REQ-019 In DONE, stall SHALL be low and request inputs SHALL be ignored; DONE SHALL return to IDLE next cycle.
REQ-020 read_data SHALL hold its value until the next completed read; writes SHALL NOT change it.
REQ-021 Misaligned request in IDLE: SHALL NOT access the array, SHALL NOT assert stall, SHALL pulse misaligned, SHALL set read_data = 0, SHALL stay in IDLE.
REQ-022 Read and write both high on acceptance: SHALL be treated as a write, SHALL pulse conflict.
REQ-023 Address bits above ADDR_W+1 SHALL be ignored (aliasing wrap).
REQ-024 Input changes during WAIT SHALL have no effect; latched values are used.

Reset
REQ-025 reset SHALL force state IDLE, counter 0, read_data 0, stall 0, misaligned 0, conflict 0, immediately and asynchronously.
REQ-026 reset during WAIT SHALL abort the access; a pending write SHALL NOT commit.
REQ-027 Array contents SHALL NOT be cleared by reset.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum (IDLE, WAIT, DONE), the op enum (OP_RD, OP_WR), and default constants for LATENCY and ADDR_W.
REQ-029 Storage SHALL be a sub-module dmem_array: single-port, synchronous write, 32-bit words, DEPTH entries.
REQ-030 FSM, counter and output registers SHALL reside in dmem_responder.

Verification
REQ-031 LATENCY=2: write 0xDEADBEEF at 0x40, then read 0x40 -> stall high 3 cycles per access, read_data = 0xDEADBEEF the cycle after DONE.
REQ-032 LATENCY=0: read 0x44 after writing 0x12345678 -> stall high exactly 1 cycle, read_data = 0x12345678.
REQ-033 Read at 0x42 -> misaligned pulses 1 cycle, stall never high, read_data = 0, array unchanged.
REQ-034 mem_read=mem_write=1, address 0x80, data 0xA5A5A5A5 -> conflict pulses; later read 0x80 returns 0xA5A5A5A5.
REQ-035 LATENCY=3: write 0x11111111 to 0x10, assert reset during the 2nd WAIT cycle -> all outputs 0 at once; later read 0x10 returns prior contents, not 0x11111111.
REQ-036 ADDR_W=10: write 0xCAFEF00D at 0x1000 -> read at 0x0000 returns 0xCAFEF00D.
